// File: rtl/order_dispatcher_if.sv
// Order dispatcher bus: parsed-order input side, per-book busy/start
// handshake, and the registered payload presented to the started book.
//   slave  : the dispatcher (consumes orders and busy, drives starts/payload)
//   master : the environment (parser + order books)
// Signals:
//   i_valid, i_stock_symbol, i_order_type, i_trade_type,
//   i_order_id, i_price, i_quantity      parsed order from the parser
//   i_book_busy                          per-book busy, bit n = book n
//   o_book_start                         one-hot start strobe to a book
//   o_order_type, o_trade_type,
//   o_order_id, o_price, o_quantity      payload for the started book
//   o_full                               queue full (parser back-pressure)
//   o_drop_count                         orders discarded since reset
interface order_dispatcher_if #(
    parameter int REG_WIDTH = 32
);
    logic                 i_valid;
    logic [1:0]           i_stock_symbol;
    logic [1:0]           i_order_type;
    logic                 i_trade_type;
    logic [REG_WIDTH-1:0] i_order_id;
    logic [REG_WIDTH-1:0] i_price;
    logic [REG_WIDTH-1:0] i_quantity;
    logic [3:0]           i_book_busy;
    logic [3:0]           o_book_start;
    logic [1:0]           o_order_type;
    logic                 o_trade_type;
    logic [REG_WIDTH-1:0] o_order_id;
    logic [REG_WIDTH-1:0] o_price;
    logic [REG_WIDTH-1:0] o_quantity;
    logic                 o_full;
    logic [15:0]          o_drop_count;

    modport slave (
        input  i_valid, i_stock_symbol, i_order_type, i_trade_type,
               i_order_id, i_price, i_quantity, i_book_busy,
        output o_book_start, o_order_type, o_trade_type,
               o_order_id, o_price, o_quantity, o_full, o_drop_count
    );

    modport master (
        output i_valid, i_stock_symbol, i_order_type, i_trade_type,
               i_order_id, i_price, i_quantity, i_book_busy,
        input  o_book_start, o_order_type, o_trade_type,
               o_order_id, o_price, o_quantity, o_full, o_drop_count
    );
endinterface

// File: rtl/order_dispatcher.sv
// Order dispatcher: queues parsed orders in a strict FIFO shared by all four
// symbols and issues them one at a time to their order book. An order is
// issued only when its book is not busy; a busy head blocks the whole queue.
// Each issue is IDLE -> ISSUE (one-cycle start strobe) -> HOLD (lets the book
// raise busy) -> IDLE, so starts are at least three cycles apart.
// Ports:
//   i_clk    clock, all state on rising edge
//   i_rst_n  synchronous active-low reset
//   bus      order_dispatcher_if slave modport (orders in, starts/payload out)
module order_dispatcher #(
    parameter int REG_WIDTH  = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    order_dispatcher_if.slave   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [1:0]           sym_mem   [FIFO_DEPTH];
    logic [1:0]           otype_mem [FIFO_DEPTH];
    logic                 ttype_mem [FIFO_DEPTH];
    logic [REG_WIDTH-1:0] id_mem    [FIFO_DEPTH];
    logic [REG_WIDTH-1:0] price_mem [FIFO_DEPTH];
    logic [REG_WIDTH-1:0] qty_mem   [FIFO_DEPTH];

    logic [1:0] head_sym;
    logic       pop;
    logic       push;
    logic       drop;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign head_sym = sym_mem[rd_ptr];
    // Pops only happen from IDLE, so busy changes during ISSUE/HOLD cannot
    // disturb an order already in flight.
    assign pop  = (state == IDLE) && (count != '0) && !bus.i_book_busy[head_sym];
    // A full queue still accepts an order when the head leaves on the same edge.
    assign push = bus.i_valid && (bus.i_order_type != 2'd3) &&
                  ((count < DEPTH_C) || pop);
    assign drop = bus.i_valid && !push;

    assign bus.o_full = (count == DEPTH_C);

    // Queue storage holds data only; validity is tracked by pointers/count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            sym_mem[wr_ptr]   <= bus.i_stock_symbol;
            otype_mem[wr_ptr] <= bus.i_order_type;
            ttype_mem[wr_ptr] <= bus.i_trade_type;
            id_mem[wr_ptr]    <= bus.i_order_id;
            price_mem[wr_ptr] <= bus.i_price;
            qty_mem[wr_ptr]   <= bus.i_quantity;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            bus.o_drop_count <= '0;
            bus.o_book_start <= '0;
            bus.o_order_type <= '0;
            bus.o_trade_type <= 1'b0;
            bus.o_order_id   <= '0;
            bus.o_price      <= '0;
            bus.o_quantity   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) bus.o_drop_count <= sat_inc(bus.o_drop_count);

            bus.o_book_start <= '0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        state            <= ISSUE;
                        bus.o_book_start <= 4'b0001 << head_sym;
                        bus.o_order_type <= otype_mem[rd_ptr];
                        bus.o_trade_type <= ttype_mem[rd_ptr];
                        bus.o_order_id   <= id_mem[rd_ptr];
                        bus.o_price      <= price_mem[rd_ptr];
                        bus.o_quantity   <= qty_mem[rd_ptr];
                    end
                end
                ISSUE:   state <= HOLD;
                HOLD:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
